// File: rtl/bus_cmd_master_pkg.sv
// Shared definitions for the byte-stream bus command master.
package bus_cmd_defs;

    // Frame opcodes
    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;

    // Default response bytes
    localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    // Command FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_BUS_WR = 3'd3,
        S_BUS_RD = 3'd4,
        S_RESP   = 3'd5
    } bus_state_t;

endpackage

// File: rtl/bus_cmd_master_byte_shift4.sv
// 4-byte little-endian register: assembles bytes in at a 2-bit index,
// or is parallel-loaded and then walked out one byte at a time.
module byte_shift4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        put,
    input  logic [7:0]  put_byte,
    input  logic        advance,
    output logic [31:0] word,
    output logic        last,
    output logic [7:0]  next_byte
);

    logic [1:0] idx;

    // Word storage and byte index; load beats clear beats put beats advance
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= load_word;
            idx  <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (put) begin
            word[{idx, 3'b000} +: 8] <= put_byte;
            idx                      <= idx + 2'd1;
        end else if (advance) begin
            idx <= idx + 2'd1;
        end
    end

    assign last = (idx == 2'd3);

    // Byte that follows the current index, used when serializing
    always_comb begin
        next_byte = word[7:0];
        case (idx)
            2'd0:    next_byte = word[15:8];
            2'd1:    next_byte = word[23:16];
            2'd2:    next_byte = word[31:24];
            default: next_byte = word[7:0];
        endcase
    end

endmodule

// File: rtl/bus_cmd_master.sv
// Byte-stream command initiator: decodes framed read/write commands from an
// rx byte stream, drives the peripheral register bus and returns ack or
// read data bytes on a tx byte stream.
module bus_cmd_master
    import bus_cmd_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    output logic        busy_o,
    output logic        err_o
);

    bus_state_t  state;
    logic        is_write;
    logic [31:0] gap;
    logic [2:0]  resp_cnt;

    logic        rx_accept;
    logic        tx_accept;
    logic        addr_last;
    logic        wdata_last;
    logic [7:0]  addr_next_unused;
    logic [7:0]  wdata_next_unused;
    logic [31:0] resp_word_unused;
    logic        resp_last_unused;
    logic [7:0]  resp_next;
    logic        unused_bits;

    assign rx_accept = rx_valid_i && rx_ready_o;
    assign tx_accept = tx_valid_o && tx_ready_i;

    byte_shift4 u_addr (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == S_IDLE && rx_accept),
        .load      (1'b0),
        .load_word ('0),
        .put       (state == S_ADDR && rx_accept),
        .put_byte  (rx_data_i),
        .advance   (1'b0),
        .word      (addr_o),
        .last      (addr_last),
        .next_byte (addr_next_unused)
    );

    byte_shift4 u_wdata (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == S_IDLE && rx_accept),
        .load      (1'b0),
        .load_word ('0),
        .put       (state == S_WDATA && rx_accept),
        .put_byte  (rx_data_i),
        .advance   (1'b0),
        .word      (wdata_o),
        .last      (wdata_last),
        .next_byte (wdata_next_unused)
    );

    byte_shift4 u_resp (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .load      (state == S_BUS_RD),
        .load_word (rdata_i),
        .put       (1'b0),
        .put_byte  ('0),
        .advance   (state == S_RESP && tx_accept),
        .word      (resp_word_unused),
        .last      (resp_last_unused),
        .next_byte (resp_next)
    );

    assign unused_bits = ^{addr_next_unused, wdata_next_unused,
                           resp_word_unused, resp_last_unused};

    // Command FSM with frame timeout; all handshake and status outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            is_write   <= 1'b0;
            gap        <= '0;
            resp_cnt   <= '0;
            rx_ready_o <= 1'b1;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            we_o       <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            we_o  <= 1'b0;
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    gap <= '0;
                    if (rx_accept) begin
                        busy_o <= 1'b1;
                        if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
                            state    <= S_ADDR;
                            is_write <= (rx_data_i == OP_WR);
                        end else begin
                            state      <= S_RESP;
                            rx_ready_o <= 1'b0;
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= ERR_BYTE;
                            resp_cnt   <= 3'd1;
                            err_o      <= 1'b1;
                        end
                    end
                end
                S_ADDR, S_WDATA: begin
                    if (rx_accept) begin
                        gap <= '0;
                        if (state == S_ADDR && addr_last) begin
                            if (is_write) begin
                                state <= S_WDATA;
                            end else begin
                                state      <= S_BUS_RD;
                                rx_ready_o <= 1'b0;
                            end
                        end else if (state == S_WDATA && wdata_last) begin
                            state      <= S_BUS_WR;
                            rx_ready_o <= 1'b0;
                            we_o       <= 1'b1;
                        end
                    end else if (gap == TIMEOUT_CYCLES - 1) begin
                        // Abort silently apart from the err pulse
                        state  <= S_IDLE;
                        gap    <= '0;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                    end else begin
                        gap <= gap + 32'd1;
                    end
                end
                S_BUS_WR: begin
                    state      <= S_RESP;
                    tx_valid_o <= 1'b1;
                    tx_data_o  <= ACK_BYTE;
                    resp_cnt   <= 3'd1;
                end
                S_BUS_RD: begin
                    state      <= S_RESP;
                    tx_valid_o <= 1'b1;
                    tx_data_o  <= rdata_i[7:0];
                    resp_cnt   <= 3'd4;
                end
                S_RESP: begin
                    if (tx_accept) begin
                        if (resp_cnt == 3'd1) begin
                            state      <= S_IDLE;
                            tx_valid_o <= 1'b0;
                            rx_ready_o <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            tx_data_o <= resp_next;
                        end
                        resp_cnt <= resp_cnt - 3'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    rx_ready_o <= 1'b1;
                    tx_valid_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master: vector table of frames plus
// hand-written latency, backpressure, timeout and reset sequences.
module tb_bus_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;
    logic        busy_o;
    logic        err_o;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  txq[$];
    int          we_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned nresp;
        logic [31:0] resp;
        int          nwe;
        int          nerr;
    } vec_t;

    vec_t vecs[5];

    bus_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .rdata_i    (rdata_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Slave model: fixed word at address 0, address-derived word elsewhere
    assign rdata_i = (addr_o == 32'h0) ? 32'h12345678 : {addr_o[15:0], 16'hBEEF};

    // Observe bus writes, error pulses and tx handshakes mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
            if (we_o) begin
                we_cnt     <= we_cnt + 1;
                last_waddr <= addr_o;
                last_wdata <= wdata_o;
            end
            if (err_o) err_cnt <= err_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        while (!rx_ready_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready_o) check("rx_ready_timeout", {31'd0, rx_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op);
        if (op == 8'h01 || op == 8'h02) send_word(a);
        if (op == 8'h01) send_word(d);
    endtask

    task automatic wait_resp(input string name, input int unsigned n);
        int unsigned k = 0;
        while (txq.size() < n && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({name, "_count"}, txq.size(), n);
    endtask

    function automatic logic [31:0] packed_resp();
        logic [31:0] w = '0;
        for (int unsigned k = 0; k < txq.size() && k < 4; k++) w[8*k +: 8] = txq[k];
        return w;
    endfunction

    task automatic run_vec(input vec_t v);
        int we0 = we_cnt;
        int er0 = err_cnt;
        txq.delete();
        send_frame(v.op, v.addr, v.data);
        wait_resp(v.name, v.nresp);
        check({v.name, "_resp"}, packed_resp(), v.resp);
        check({v.name, "_we_cycles"}, we_cnt - we0, v.nwe);
        if (v.nwe != 0) begin
            check({v.name, "_waddr"}, last_waddr, v.addr);
            check({v.name, "_wdata"}, last_wdata, v.data);
        end
        check({v.name, "_err"}, err_cnt - er0, v.nerr);
        check({v.name, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int          we0;
        int          n;
        int unsigned stall_bad;

        vecs[0] = '{"wr4",    8'h01, 32'h00000004, 32'h0000000F, 1, 32'h000000A5, 1, 0};
        vecs[1] = '{"rd0",    8'h02, 32'h00000000, 32'h0,        4, 32'h12345678, 0, 0};
        vecs[2] = '{"badop",  8'h7F, 32'h0,        32'h0,        1, 32'h000000EE, 0, 1};
        vecs[3] = '{"wrhi",   8'h01, 32'h10000008, 32'hDEADBEEF, 1, 32'h000000A5, 1, 0};
        vecs[4] = '{"rd10",   8'h02, 32'h00000010, 32'h0,        4, 32'h0010BEEF, 0, 0};

        rst        = 1'b1;
        rx_data_i  = '0;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        @(posedge clk);
        #1;

        for (int unsigned i = 0; i < 5; i++) run_vec(vecs[i]);

        // Write latency: we_o in the cycle after the last data byte, ACK the cycle after
        tx_ready_i = 1'b0;
        txq.delete();
        we0 = we_cnt;
        send_frame(8'h01, 32'h00000020, 32'h55AA0011);
        @(negedge clk);
        check("lat_we", {31'd0, we_o}, 32'd1);
        check("lat_we_addr", addr_o, 32'h00000020);
        check("lat_we_wdata", wdata_o, 32'h55AA0011);
        check("lat_we_txv", {31'd0, tx_valid_o}, 32'd0);
        check("lat_we_rdy", {31'd0, rx_ready_o}, 32'd0);
        @(negedge clk);
        check("lat_ack_we", {31'd0, we_o}, 32'd0);
        check("lat_ack_txv", {31'd0, tx_valid_o}, 32'd1);
        check("lat_ack_data", {24'd0, tx_data_o}, 32'h000000A5);
        @(posedge clk);
        #1;
        tx_ready_i = 1'b1;
        wait_resp("lat", 1);
        check("lat_resp", packed_resp(), 32'h000000A5);
        check("lat_we_cycles", we_cnt - we0, 1);

        // Backpressure on a read: first byte held for 10 cycles
        tx_ready_i = 1'b0;
        txq.delete();
        we0 = we_cnt;
        send_frame(8'h02, 32'h0, 32'h0);
        n = 0;
        while (!tx_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", {31'd0, tx_valid_o}, 32'd1);
        stall_bad = 0;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!tx_valid_o || tx_data_o != 8'h78) stall_bad++;
        end
        check("bp_hold", stall_bad, 32'd0);
        @(posedge clk);
        #1;
        tx_ready_i = 1'b1;
        wait_resp("bp", 4);
        check("bp_resp", packed_resp(), 32'h12345678);
        check("bp_we", we_cnt - we0, 0);

        // Timeout: 01,04 then silence
        txq.delete();
        we0 = we_cnt;
        send_byte(8'h01);
        send_byte(8'h04);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_o && n < 40);
        check("to_err_cycle", n, 17);
        check("to_busy", {31'd0, busy_o}, 32'd0);
        check("to_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("to_no_we", we_cnt - we0, 0);
        check("to_no_tx", txq.size(), 0);
        run_vec(vecs[0]);

        // Reset while the third data byte is presented
        we0 = we_cnt;
        send_byte(8'h01);
        send_word(32'h00000004);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_data_i  = 8'h33;
        rx_valid_i = 1'b1;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        rx_valid_i = 1'b0;
        @(negedge clk);
        check("mid_rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        check("mid_rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("mid_rst_addr", addr_o, 32'd0);
        check("mid_rst_wdata", wdata_o, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_we", we_cnt - we0, 0);
        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
